// File: rtl/mmio_store_port.sv
// mmio_store_port: MMIO store FIFO with valid/ready drain, status/result registers
// Optional MMIO_STORE_PORT_IRQ_EN adds irq output and CTRL bit3 irq enable.
module mmio_store_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic        Hit,
    output logic [31:0] ReadData,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
`ifdef MMIO_STORE_PORT_IRQ_EN
    output logic        irq,
`endif
    output logic        done,
    output logic [31:0] result
);
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic overflow, full, empty, pop, push, drop, flush;
    logic we, wr_data, wr_ctrl, wr_res;
    logic [1:0] off;
    logic [31:0] status;
    logic unused_adr;

    assign unused_adr = ^Adr[1:0];
    assign Hit = Adr[31:4] == BASE_ADDR[31:4];
    assign off = Adr[3:2];
    assign we = MemWrite & Hit;
    assign wr_data = we & (off == 2'd0);
    assign wr_ctrl = we & (off == 2'd2);
    assign wr_res = we & (off == 2'd3);
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign out_valid = !empty;
    assign pop = out_valid & out_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push = wr_data & (!full | pop);
    assign drop = wr_data & full & !pop;
    assign flush = wr_ctrl & WriteData[1];
    assign out_data = empty ? '0 : mem[rd_ptr];
    assign status = {24'b0, 4'(count), overflow, full, empty, done};

    always_comb begin
        ReadData = !Hit ? '0 :
                   off == 2'd0 ? out_data :
                   off == 2'd1 ? status :
                   off == 2'd3 ? result : '0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
            overflow <= drop | (overflow & !(wr_ctrl & WriteData[0]));
            done     <= wr_res | (done & !(wr_ctrl & WriteData[2]));
            if (wr_res)
                result <= WriteData;
        end
    end

`ifdef MMIO_STORE_PORT_IRQ_EN
    logic irq_en;
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl)
                irq_en <= WriteData[3];
            irq <= irq_en & (overflow | done);
        end
    end
`endif
endmodule

// File: tb/tb_mmio_store_port.sv
// tb_mmio_store_port: table vectors plus queue scoreboard for mmio_store_port
module tb_mmio_store_port;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] Adr = '0, WriteData = '0;
    logic MemWrite = 1'b0, out_ready = 1'b0;
    logic Hit, out_valid, done;
    logic [31:0] ReadData, out_data, result;
`ifdef MMIO_STORE_PORT_IRQ_EN
    logic irq;
`endif
    int checks = 0, errors = 0;
    logic [31:0] q[$];
    logic m_done = 1'b0;
    logic [31:0] m_result = '0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wd;
        logic        mw;
        logic        rdy;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[5];

    mmio_store_port dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .MemWrite(MemWrite),
        .Hit(Hit), .ReadData(ReadData), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready),
`ifdef MMIO_STORE_PORT_IRQ_EN
        .irq(irq),
`endif
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                        input logic rdy, input logic chk, input logic [31:0] exp);
        logic hit_m, pop_m, acc;
        Adr = a; WriteData = wd; MemWrite = mw; out_ready = rdy;
        #1;
        hit_m = a[31:4] == 28'h000_0010;
        check("hit", Hit, hit_m);
        if (chk) check("readdata", ReadData, exp);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() == 0) check("out_data_empty", out_data, 0);
        pop_m = (q.size() != 0) && rdy;
        acc = (q.size() < 8) || pop_m;
        if (pop_m) begin
            check("pop_data", out_data, q[0]);
            void'(q.pop_front());
        end
        if (mw && hit_m) begin
            case (a[3:2])
                2'd0: if (acc) q.push_back(wd);
                2'd2: begin
                    if (wd[1]) q.delete();
                    if (wd[2]) m_done = 1'b0;
                end
                2'd3: begin m_result = wd; m_done = 1'b1; end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        MemWrite = 1'b0;
        check("done", done, m_done);
        check("result", result, m_result);
    endtask

    task automatic do_reset();
        reset = 1'b1; MemWrite = 1'b0; out_ready = 1'b0; Adr = 32'h104;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); m_done = 1'b0; m_result = '0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_status", ReadData, 32'h02);
    endtask

    initial begin
        tbl[0] = '{32'h100, 32'hA5, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[1] = '{32'h104, 32'h0,  1'b0, 1'b0, 1'b1, 32'h10};
        tbl[2] = '{32'h100, 32'h0,  1'b0, 1'b0, 1'b1, 32'hA5};
        tbl[3] = '{32'h108, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0};
        tbl[4] = '{32'h104, 32'h0,  1'b0, 1'b0, 1'b1, 32'h02};
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 5; i++)
            step(tbl[i].adr, tbl[i].wd, tbl[i].mw, tbl[i].rdy, tbl[i].chk, tbl[i].exp);
        // fill past full: 9 dropped, overflow set
        for (int i = 1; i <= 9; i++) step(32'h100, i, 1'b1, 1'b0, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h8C);
        for (int i = 0; i < 8; i++) step(32'h0, 0, 1'b0, 1'b1, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h0A);
        step(32'h108, 1, 1'b1, 1'b0, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h02);
        // push into full FIFO together with a pop
        for (int i = 0; i < 8; i++) step(32'h100, 32'h20 + i, 1'b1, 1'b0, 1'b0, 0);
        step(32'h100, 32'h55, 1'b1, 1'b1, 1'b1, 32'h20);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h84);
        for (int i = 0; i < 8; i++) step(32'h0, 0, 1'b0, 1'b1, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h02);
        // result / done
        step(32'h10C, 7, 1'b1, 1'b0, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h03);
        step(32'h10C, 0, 1'b0, 1'b0, 1'b1, 32'h7);
        step(32'h108, 4, 1'b1, 1'b0, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h02);
        // flush while popping, then an out-of-window store
        for (int i = 0; i < 3; i++) step(32'h100, 32'h30 + i, 1'b1, 1'b0, 1'b0, 0);
        step(32'h108, 2, 1'b1, 1'b1, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b1, 1'b1, 32'h02);
        step(32'h60, 32'hDEAD, 1'b1, 1'b0, 1'b1, 32'h0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h02);
        // reset mid-transfer with overflow and done set
        step(32'h10C, 9, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) step(32'h100, 32'h40 + i, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(32'h0, 0, 1'b0, 1'b1, 1'b0, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h59);
        do_reset();
`ifdef MMIO_STORE_PORT_IRQ_EN
        step(32'h108, 8, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) step(32'h100, i, 1'b1, 1'b0, 1'b0, 0);
        check("irq_early", irq, 0);
        step(32'h104, 0, 1'b0, 1'b0, 1'b1, 32'h8C);
        check("irq", irq, 1);
        do_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
